spawn_tx: RTL and testbench

Serial transmitter that sends the spawn command byte to the peer board over the inter-board UART link. Game logic raises `spawn_req` when the local player triggers a spawn. The block serialises one 8N1 frame carrying `SPAWN_CODE` on `tx`, and the peer's receive path turns that frame into a rectangle spawn. It sits between local game logic and the board's UART TX pin.

---
 rtl/spawn_tx.sv | 193 +++++++++++++++++++
 tb/tb_spawn_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spawn_tx.sv
// spawn_tx
//
// Serial transmitter that sends the spawn command byte to the peer board over
// the inter-board UART link. A rising edge on spawn_req sends one 8N1 frame
// carrying SPAWN_CODE on tx; an edge that arrives while a frame is in flight
// is remembered in a one-deep pending flag, so that frame follows back-to-back.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   SPAWN_CODE    byte transmitted per request
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   spawn_req  spawn request level, only its rising edge counts
//   tx         UART serial line, idle high, driven straight from a flop
//   busy       high while a frame is being sent or one is pending
//   sent       one-cycle pulse in the final cycle of a frame's stop bit
//
// Build option:
//   SPAWN_TX_PARITY_EN  when defined, an even parity bit is inserted between
//                       the data bits and the stop bit (8E1, 11-bit frame).

module spawn_tx #(
  parameter int          CLKS_PER_BIT = 564,
  parameter logic [7:0]  SPAWN_CODE   = 8'h61
) (
  input  logic clk,
  input  logic rst,
  input  logic spawn_req,
  output logic tx,
  output logic busy,
  output logic sent
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SPAWN_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] clk_cnt, cnt_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shift_q, shift_n;
  logic          pending, pend_n;
  logic          spawn_req_q;
  logic          req_edge;
  logic          cnt_last;
  logic          tx_n, busy_n, sent_n;

  assign req_edge = spawn_req & ~spawn_req_q;
  assign cnt_last = (clk_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      pending     <= 1'b0;
      spawn_req_q <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      sent        <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= cnt_n;
      bit_idx     <= idx_n;
      shift_q     <= shift_n;
      pending     <= pend_n;
      spawn_req_q <= spawn_req;
      tx          <= tx_n;
      busy        <= busy_n;
      sent        <= sent_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = clk_cnt;
    idx_n   = bit_idx;
    shift_n = shift_q;
    pend_n  = pending;
    tx_n    = 1'b1;
    busy_n  = 1'b0;
    sent_n  = 1'b0;

    // Any edge outside IDLE is remembered; a second one is absorbed because
    // the flag is already set.
    if (req_edge && (state != IDLE)) begin
      pend_n = 1'b1;
    end

    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (req_edge) begin
          shift_n = SPAWN_CODE;
          state_n = START;
        end
      end

      START: begin
        if (cnt_last) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = clk_cnt + ONE;
        end
      end

      DATA: begin
        if (cnt_last) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift_q[7:1]};
          if (bit_idx == 3'd7) begin
            idx_n   = '0;
`ifdef SPAWN_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = clk_cnt + ONE;
        end
      end

`ifdef SPAWN_TX_PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = STOP;
        end else begin
          cnt_n = clk_cnt + ONE;
        end
      end
`endif

      STOP: begin
        if (cnt_last) begin
          cnt_n = '0;
          // An edge landing on this very cycle is treated like a pending
          // request so the next start bit follows with no idle gap.
          if (pending || req_edge) begin
            pend_n  = 1'b0;
            shift_n = SPAWN_CODE;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = clk_cnt + ONE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        pend_n  = 1'b0;
      end
    endcase

    // Outputs are computed from the next state so the flops present them in
    // the same cycle the state register does.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef SPAWN_TX_PARITY_EN
      PARITY:  tx_n = ^SPAWN_CODE;
`endif
      default: tx_n = 1'b1;
    endcase

    busy_n = (state_n != IDLE) | pend_n;
    sent_n = (state_n == STOP) && (cnt_n == LAST);
  end

endmodule

// File: tb/tb_spawn_tx.sv
// tb_spawn_tx
//
// Self-checking bench for spawn_tx with CLKS_PER_BIT=4 and SPAWN_CODE=8'h61.
// A frame-level reference model (frame position counter plus pending flag)
// predicts tx, busy and sent every cycle; directed scenarios add literal
// expectations for the bit pattern, sent timing and frame counts.

module tb_spawn_tx;

  localparam int         CPB  = 4;
  localparam logic [7:0] CODE = 8'h61;
`ifdef SPAWN_TX_PARITY_EN
  localparam int         NBITS   = 11;
  localparam int         SENT_AT = 44;
`else
  localparam int         NBITS   = 10;
  localparam int         SENT_AT = 40;
`endif
  localparam int         FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spawn_req = 1'b0;
  logic tx, busy, sent;

  int total = 0;
  int bad = 0;
  int dut_sent_count = 0;
  bit cmp_en = 1'b0;

  logic [10:0] pattern;

  // Model state: whether a frame is on the wire, position inside it, and
  // the one-deep pending request.
  bit m_active = 1'b0;
  bit m_pend   = 1'b0;
  bit m_req_q  = 1'b0;
  int m_pos    = 0;

  always #5 clk = ~clk;

  spawn_tx #(
    .CLKS_PER_BIT(CPB),
    .SPAWN_CODE  (CODE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .spawn_req(spawn_req),
    .tx       (tx),
    .busy     (busy),
    .sent     (sent)
  );

  function automatic logic frame_bit(input int k);
    logic [7:0] code_v;
    code_v = CODE;
    if (k == 0) return 1'b0;
    if (k <= 8) return code_v[k-1];
    if (k == 9 && NBITS == 11) return ^code_v;
    return 1'b1;
  endfunction

  task automatic check_output(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_count(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances one frame position per clock.
  always @(posedge clk or negedge rst) begin
    bit edge_seen;
    if (!rst) begin
      m_active = 1'b0;
      m_pend   = 1'b0;
      m_req_q  = 1'b0;
      m_pos    = 0;
    end else begin
      edge_seen = spawn_req && !m_req_q;
      m_req_q   = spawn_req;
      if (m_active) begin
        if (m_pos == FRAME - 1) begin
          if (m_pend || edge_seen) begin
            m_pos  = 0;
            m_pend = 1'b0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_pos++;
          if (edge_seen) m_pend = 1'b1;
        end
      end else if (edge_seen) begin
        m_active = 1'b1;
        m_pos    = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model_tx",   tx,   m_active ? frame_bit(m_pos / CPB) : 1'b1);
      check_output("model_busy", busy, m_active || m_pend);
      check_output("model_sent", sent, m_active && (m_pos == FRAME - 1));
      if (sent === 1'b1) dut_sent_count++;
    end
  end

  task automatic apply_stimulus(input int width);
    @(negedge clk);
    spawn_req = 1'b1;
    repeat (width) @(negedge clk);
    spawn_req = 1'b0;
  endtask

  initial begin
    int base;
    int busy_cycles;
    int sent_cycle;
    bit found;

`ifdef SPAWN_TX_PARITY_EN
    pattern = 11'b11011000010;
`else
    pattern = 11'b01011000010;
`endif

    $display("[TB] start, frame=%0d cycles", FRAME);

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check_output("reset_tx",   tx,   1'b1);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_sent", sent, 1'b0);
    repeat (100) @(negedge clk);
    check_count("idle_no_frame", dut_sent_count, 0);

    // Single one-cycle request with literal bit pattern and sent timing
    @(negedge clk);
    spawn_req = 1'b1;
    sent_cycle = -1;
    for (int k = 1; k <= FRAME + 1; k++) begin
      @(negedge clk);
      spawn_req = 1'b0;
      if ((k % CPB) == 2)
        check_output($sformatf("pattern_bit%0d", k / CPB), tx, pattern[k / CPB]);
      if (sent === 1'b1 && sent_cycle < 0) sent_cycle = k;
    end
    check_count("single_sent_cycle", sent_cycle, SENT_AT);
    check_output("single_busy_after", busy, 1'b0);
    check_count("single_sent_total", dut_sent_count, 1);

    // Held level for 200 cycles
    base = dut_sent_count;
    apply_stimulus(200);
    repeat (60) @(negedge clk);
    check_count("held_one_frame", dut_sent_count - base, 1);

    // Requests while busy: second during DATA, third before frame end
    base = dut_sent_count;
    busy_cycles = 0;
    @(negedge clk);
    spawn_req = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 1)  spawn_req = 1'b0;
      if (k == 15) spawn_req = 1'b1;
      if (k == 16) spawn_req = 1'b0;
      if (k == 28) spawn_req = 1'b1;
      if (k == 29) spawn_req = 1'b0;
      if (busy === 1'b1) busy_cycles++;
    end
    check_count("busy_two_frames", busy_cycles, 2 * FRAME);
    check_count("busy_sent_two", dut_sent_count - base, 2);

    // Edge on the final stop cycle
    base = dut_sent_count;
    apply_stimulus(1);
    found = 1'b0;
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      @(negedge clk);
      if (sent === 1'b1) found = 1'b1;
    end
    check_output("stopedge_sent_seen", found, 1'b1);
    spawn_req = 1'b1;
    @(negedge clk);
    check_output("stopedge_tx_start", tx, 1'b0);
    check_output("stopedge_busy", busy, 1'b1);
    spawn_req = 1'b0;
    repeat (FRAME + 10) @(negedge clk);
    check_count("stopedge_frames", dut_sent_count - base, 2);

    // Reset during data bit 3
    base = dut_sent_count;
    apply_stimulus(1);
    repeat (17) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("midreset_tx",   tx,   1'b1);
    check_output("midreset_busy", busy, 1'b0);
    check_output("midreset_sent", sent, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check_count("midreset_no_sent", dut_sent_count - base, 0);
    apply_stimulus(1);
    repeat (FRAME + 5) @(negedge clk);
    check_count("midreset_clean_frame", dut_sent_count - base, 1);

    // Random request traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) spawn_req = ~spawn_req;
    end
    spawn_req = 1'b0;
    repeat (2 * FRAME + 5) @(negedge clk);
    check_output("final_idle_busy", busy, 1'b0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
